// File: rtl/demux_4way.sv
// demux_4way: registered 1-to-4 demultiplexer.
// Each clock edge steers the input word to the lane that ctrl selects.
// The other three lanes load zero on that same edge, so at most one lane
// is ever nonzero. Every output comes straight from a flop.
module demux_4way #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       ctrl,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4
);

  logic [WIDTH-1:0] out1_d, out2_d, out3_d, out4_d;
  logic [WIDTH-1:0] out1_q, out2_q, out3_q, out4_q;

  // Decode ctrl: the selected lane takes the input word and every other lane takes zero.
  always_comb begin
    out1_d = '0;
    out2_d = '0;
    out3_d = '0;
    out4_d = '0;
    case (ctrl)
      2'd0: out1_d = in;
      2'd1: out2_d = in;
      2'd2: out3_d = in;
      2'd3: out4_d = in;
    endcase
  end

  // Lane registers. Reset clears them at once, without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out1_q <= '0;
      out2_q <= '0;
      out3_q <= '0;
      out4_q <= '0;
    end else begin
      out1_q <= out1_d;
      out2_q <= out2_d;
      out3_q <= out3_d;
      out4_q <= out4_d;
    end
  end

  assign out1 = out1_q;
  assign out2 = out2_q;
  assign out3 = out3_q;
  assign out4 = out4_q;

endmodule

// File: tb/tb_demux_4way.sv
// tb_demux_4way: directed self-checking bench for demux_4way.
module tb_demux_4way;

  localparam int WIDTH = 64;
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO     = '0;

  logic             clk;
  logic             clkEn;
  logic             rst_n;
  logic [1:0]       ctrl;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out1, out2, out3, out4;

  int testsRun;
  int testsFailed;

  demux_4way #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ctrl (ctrl),
    .in   (in),
    .out1 (out1),
    .out2 (out2),
    .out3 (out3),
    .out4 (out4)
  );

  // Free-running clock, held low until clkEn is set so reset can be checked without edges.
  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clkEn) clk = ~clk;
      else       clk = 1'b0;
    end
  end

  // Compare one lane against its expected value.
  task automatic checkLane(input string tag, input logic [WIDTH-1:0] observed,
                           input logic [WIDTH-1:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Compare all four lanes.
  task automatic checkOutput(input string tag,
                             input logic [WIDTH-1:0] e1, input logic [WIDTH-1:0] e2,
                             input logic [WIDTH-1:0] e3, input logic [WIDTH-1:0] e4);
    checkLane({tag, ".out1"}, out1, e1);
    checkLane({tag, ".out2"}, out2, e2);
    checkLane({tag, ".out3"}, out3, e3);
    checkLane({tag, ".out4"}, out4, e4);
  endtask

  // Drive inputs, then advance to just after the next rising edge.
  task automatic applyStimulus(input logic [1:0] c, input logic [WIDTH-1:0] d);
    ctrl = c;
    in   = d;
    @(posedge clk);
    #1;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    clkEn       = 1'b0;
    rst_n       = 1'b1;
    ctrl        = 2'd2;
    in          = ALL_ONES;

    // Reset with no clock running: outputs must clear asynchronously.
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", ZERO, ZERO, ZERO, ZERO);

    // Clock runs while reset is held: outputs stay zero.
    clkEn = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("hold_reset", ZERO, ZERO, ZERO, ZERO);
    rst_n = 1'b1;

    // Sweep in=100 across all four lanes.
    applyStimulus(2'd0, 64'd100);
    checkOutput("sweep0", 64'd100, ZERO, ZERO, ZERO);
    applyStimulus(2'd1, 64'd100);
    checkOutput("sweep1", ZERO, 64'd100, ZERO, ZERO);
    applyStimulus(2'd2, 64'd100);
    checkOutput("sweep2", ZERO, ZERO, 64'd100, ZERO);
    applyStimulus(2'd3, 64'd100);
    checkOutput("sweep3", ZERO, ZERO, ZERO, 64'd100);

    // Full-width word on lane 3, then on lane 0 for the top bits.
    applyStimulus(2'd3, ALL_ONES);
    checkOutput("full_width3", ZERO, ZERO, ZERO, ALL_ONES);
    applyStimulus(2'd0, 64'h8000_0000_0000_0001);
    checkOutput("full_width0", 64'h8000_0000_0000_0001, ZERO, ZERO, ZERO);

    // Lane switch: the old lane clears on the same edge the new one loads.
    applyStimulus(2'd1, 64'd7);
    checkOutput("switch_a", ZERO, 64'd7, ZERO, ZERO);
    applyStimulus(2'd2, 64'd9);
    checkOutput("switch_b", ZERO, ZERO, 64'd9, ZERO);

    // Latency: input changes between edges do not reach the outputs.
    #1;
    ctrl = 2'd0;
    in   = 64'd5;
    #2;
    checkOutput("latency_hold", ZERO, ZERO, 64'd9, ZERO);
    @(posedge clk);
    #1;
    checkOutput("latency_edge", 64'd5, ZERO, ZERO, ZERO);

    // A zero word leaves every lane at zero.
    applyStimulus(2'd1, ZERO);
    checkOutput("zero_word", ZERO, ZERO, ZERO, ZERO);

    // Mid-run reset while out3=42.
    applyStimulus(2'd2, 64'd42);
    checkOutput("pre_reset", ZERO, ZERO, 64'd42, ZERO);
    ctrl = 2'd3;
    in   = 64'd77;
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_reset", ZERO, ZERO, ZERO, ZERO);
    @(posedge clk);
    #1;
    checkOutput("mid_reset_hold", ZERO, ZERO, ZERO, ZERO);
    rst_n = 1'b1;

    // Normal routing resumes after release.
    applyStimulus(2'd3, 64'h0123_4567_89AB_CDEF);
    checkOutput("resume", ZERO, ZERO, ZERO, 64'h0123_4567_89AB_CDEF);
    applyStimulus(2'd2, 64'd42);
    checkOutput("resume2", ZERO, ZERO, 64'd42, ZERO);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
